outputc: RTL and testbench
==========================

# outputc

Per-physical-channel output stage of the HL router. It registers the flit selected by the crossbar and drives it onto the link toward the downstream router's `inputc`. It tracks per-VC credits against the downstream input buffers and per-VC packet ownership. The resulting per-VC ready (`ordy`) and lock (`olck`) vectors feed the `irdy_N`/`ilck_N` inputs of every `inputc` in the same router.

## Interface

**Parameters**
- `ROUTERID`, default 0: router index, used for debug only.
- `PCHID`, default 0: physical channel index, used for debug only.
- `BUF_DEPTH`, default 4: depth of each downstream VC FIFO, which is also the initial credit count.

**Ports**
- `clk`, in, 1: the single clock.
- `rst_`, in, 1: asynchronous, active-high reset.
- `idata`, in, `` `DATAW+1 ``: flit from the crossbar.
- `ivalid`, in, 1: `idata` is valid this cycle.
- `ivch`, in, `` `VCHW+1 ``: target downstream VC of `idata`.
- `iack`, in, `` `VCH+1 ``: credit return, one pulse per flit; driven by the downstream `inputc` `oack`.
- `odata`, out, `` `DATAW+1 ``: link data.
- `ovalid`, out, 1: link valid.
- `ovch`, out, `` `VCHW+1 ``: link VC id.
- `ordy`, out, `` `VCH+1 ``: per-VC, 1 when the credit count is nonzero.
- `olck`, out, `` `VCH+1 ``: per-VC, 1 while a multi-flit packet owns the VC.
- `oerr`, out, 1: sticky protocol-error flag.

## Operation

**Output register**
- On `ivalid`, capture `idata` and `ivch` and set `ovalid` at the next edge.
- When `ivalid` is low, `ovalid` returns to 0 and `odata` is forced to 0.

**Credit counters**
- One counter per VC, width `$clog2(BUF_DEPTH+1)`, reset to `BUF_DEPTH`.
- Accepted flit on VC v: decrement by 1.
- `iack[v]` high: increment by 1.
- Both in the same cycle: the counter is unchanged.
- `ordy[v] = (credit[v] != 0)`, combinational from the counter.

**Lock FSM, one per VC**
- States are IDLE and LOCKED, decoded from `` idata[`TYPE_MSB:`TYPE_LSB] `` of accepted flits.
- IDLE → LOCKED on a `` `TYPE_HEAD `` flit.
- LOCKED → IDLE on a `` `TYPE_TAIL `` flit.
- `` `TYPE_HEADTAIL `` leaves the VC in IDLE.
- `` `TYPE_BODY `` causes no transition.
- A HEAD flit in LOCKED, or a TAIL flit in IDLE, is a protocol error (see Configuration).
- `olck[v] = (state == LOCKED)`.

**Boundaries**
- Flit with `ivalid` to VC v while `credit[v] == 0`: overflow error.
- `iack[v]` while `credit[v] == BUF_DEPTH`: underflow error. The counter saturates at `BUF_DEPTH` and never wraps.
- `ivch` values above `` `VCH `` are ignored: no flit is forwarded and no state changes.

**Reset**
- Reset at any point, including mid-packet, immediately clears the output register, the locks and `oerr`, and restores all credits to `BUF_DEPTH`.
- A flit in flight at reset is lost.

## Timing

- Reset values:
  - `odata` = 0, `ovalid` = 0, `ovch` = 0.
  - `ordy` = all ones.
  - `olck` = 0.
  - `oerr` = 0.
- Latency from `idata` to `odata` is 1 cycle.
- The credit decrement is visible on `ordy` the cycle after acceptance. Upstream allocation must tolerate this one-cycle lag; `BUF_DEPTH` ≥ 2 is required.
- The lock set/clear is visible on `olck` the cycle after the HEAD/TAIL flit is accepted.
- `iack` is sampled every cycle with no handshake. Each high cycle counts as one credit.
- Throughput is 1 flit per cycle across all VCs.

## Configuration

Macro: `OUTPUTC_ERRCHK_EN`.

**Defined**
- The overflow and lock-protocol violations above set `oerr`.
- A flit that violates either rule is dropped: no `ovalid`, no credit change, no lock change.
- Underflow sets `oerr`; the counter stays saturated.
- `oerr` stays set until reset.

**Undefined**
- `oerr` is tied to 0.
- Violating flits are forwarded.
- The credit counter saturates at 0 on decrement and at `BUF_DEPTH` on increment.
- The lock FSM takes transitions unconditionally.

## Structure

- Constants shared through `define.v`:
  - flit type codes: `` `TYPE_HEAD ``, `` `TYPE_BODY ``, `` `TYPE_TAIL ``, `` `TYPE_HEADTAIL ``;
  - field bounds: `` `TYPE_MSB ``, `` `TYPE_LSB ``;
  - widths: `` `DATAW ``, `` `VCH ``, `` `VCHW ``, `` `DATAW_P1 ``.
- No new package constants are needed; the credit width is derived locally from `BUF_DEPTH`.
- One sub-module, `credit_cnt`: a per-VC counter plus lock FSM, instantiated `` `VCH+1 `` times.

## Test plan

All scenarios use `BUF_DEPTH = 4` and 3 VCs.

1. **Reset:** assert `rst_` for 2 cycles → `ordy` = 3'b111, `olck` = 0, `ovalid` = 0, `oerr` = 0.
2. **Credit exhaustion:** 4 back-to-back HEADTAIL flits on VC1 with no `iack` → `ovalid` is high on cycles 1–4 with matching `odata` and `ovch` = 1; `ordy` = 3'b101 after the 4th flit; `olck` stays 0. Then one `iack[1]` pulse → `ordy` = 3'b111.
3. **Simultaneous events:** with VC0 at credit 2, a flit on VC0 and `iack[0]` in the same cycle → credit stays 2 and `ordy[0]` = 1. Credit 1 plus a flit alone → `ordy[0]` = 0.
4. **Packet lock:** HEAD, BODY, BODY, TAIL on VC2 → `olck[2]` rises the cycle after HEAD and falls the cycle after TAIL; credit[2] is 0 after 4 flits.
5. **Error check** (`OUTPUTC_ERRCHK_EN` defined):
   - a flit on VC1 at credit 0 → no `ovalid`; `oerr` = 1 and stays 1;
   - `iack[0]` at credit 4 → credit stays 4.
6. **Reset mid-packet:** `rst_` asserted between BODY flits of a VC0 packet → in the same cycle, asynchronously, `olck[0]` = 0, `ovalid` = 0 and `ordy` = 3'b111; a new HEAD after release locks normally.

Source files
------------

// File: rtl/outputc_pkg.sv
// outputc_pkg: constants shared by the HL router output stage.
// Flit layout: [DATAW:0], flit type in [TYPE_MSB:TYPE_LSB].
// Configuration macro: OUTPUTC_ERRCHK_EN (see outputc.sv).
// The backtick macros mirror the legacy define.v names. The RTL itself
// uses the package localparams.
`ifndef OUTPUTC_DEFINES_DONE
`define OUTPUTC_DEFINES_DONE
`define DATAW         31
`define DATAW_P1      32
`define VCH           2
`define VCHW          1
`define TYPE_MSB      31
`define TYPE_LSB      30
`define TYPE_BODY     2'b00
`define TYPE_HEAD     2'b01
`define TYPE_TAIL     2'b10
`define TYPE_HEADTAIL 2'b11
`endif

package outputc_pkg;
  localparam int DATAW    = 31;
  localparam int DATAW_P1 = 32;
  localparam int VCH      = 2;
  localparam int VCHW     = 1;
  localparam int TYPE_MSB = 31;
  localparam int TYPE_LSB = 30;

  localparam logic [1:0] TYPE_BODY     = 2'b00;
  localparam logic [1:0] TYPE_HEAD     = 2'b01;
  localparam logic [1:0] TYPE_TAIL     = 2'b10;
  localparam logic [1:0] TYPE_HEADTAIL = 2'b11;

  // Extract the flit type field from a flit.
  function automatic logic [1:0] flit_type(input logic [DATAW:0] d);
    return d[TYPE_MSB:TYPE_LSB];
  endfunction
endpackage

// File: rtl/outputc_credit_cnt.sv
// credit_cnt: per-VC credit counter plus packet lock FSM for outputc.
// Configuration macro: OUTPUTC_ERRCHK_EN. When it is defined, the block
// flags overflow and lock violations so the flit can be dropped.
module credit_cnt
  import outputc_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       sel,
  input  logic [1:0] ftype,
  input  logic       ack,
  output logic       rdy,
  output logic       lck,
  output logic       viol,
  output logic       uflow
);
  localparam logic [0:0]    IDLE   = 1'b0;
  localparam logic [0:0]    LOCKED = 1'b1;
  localparam logic [CW-1:0] FULL   = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] EMPTY  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE    = {{(CW-1){1'b0}}, 1'b1};

  logic [CW-1:0] credit;
  logic [CW-1:0] credit_nxt;
  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic          dec;
  logic          is_head;
  logic          is_tail;

  // Classify the flit and decide whether it violates the VC protocol.
  always_comb begin
    is_head = (ftype == TYPE_HEAD);
    is_tail = (ftype == TYPE_TAIL);
`ifdef OUTPUTC_ERRCHK_EN
    viol  = sel && ((credit == EMPTY) ||
                    (is_head && (state == LOCKED)) ||
                    (is_tail && (state == IDLE)));
    dec   = sel && !viol;
    uflow = ack && !dec && (credit == FULL);
`else
    viol  = 1'b0;
    dec   = sel;
    uflow = 1'b0;
`endif
  end

  // Next credit: a simultaneous send and return cancel out; saturate both ends.
  always_comb begin
    credit_nxt = credit;
    if (dec && !ack) begin
      if (credit != EMPTY) credit_nxt = credit - ONE;
      else                 credit_nxt = credit;
    end else if (ack && !dec) begin
      if (credit != FULL) credit_nxt = credit + ONE;
      else                credit_nxt = credit;
    end else begin
      credit_nxt = credit;
    end
  end

  // Next lock state from the type of an accepted flit.
  always_comb begin
    state_nxt = state;
    if (dec) begin
      case (ftype)
        TYPE_HEAD: state_nxt = LOCKED;
        TYPE_TAIL: state_nxt = IDLE;
        default:   state_nxt = state;
      endcase
    end else begin
      state_nxt = state;
    end
  end

  // Credit and lock state registers.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      credit <= FULL;
      state  <= IDLE;
    end else begin
      credit <= credit_nxt;
      state  <= state_nxt;
    end
  end

  assign rdy = (credit != EMPTY);
  assign lck = (state == LOCKED);
endmodule

// File: rtl/outputc.sv
// outputc: per-physical-channel output stage of the HL router.
// Registers the crossbar flit onto the link. It tracks downstream credits
// and packet ownership per VC.
// Configuration macro: OUTPUTC_ERRCHK_EN. When defined, violating flits
// are dropped and a sticky oerr is raised. Otherwise oerr is held at 0.
module outputc
  import outputc_pkg::*;
#(
  parameter int ROUTERID  = 0,
  parameter int PCHID     = 0,
  parameter int BUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [DATAW:0]  idata,
  input  logic            ivalid,
  input  logic [VCHW:0]   ivch,
  input  logic [VCH:0]    iack,
  output logic [DATAW:0]  odata,
  output logic            ovalid,
  output logic [VCHW:0]   ovch,
  output logic [VCH:0]    ordy,
  output logic [VCH:0]    olck,
  output logic            oerr
);
  localparam int NVC = VCH + 1;
  localparam int CHW = VCHW + 1;

`ifdef OUTPUTC_ERRCHK_EN
  localparam logic ERRCHK = 1'b1;
`else
  localparam logic ERRCHK = 1'b0;
`endif

  logic [VCH:0] sel;
  logic [VCH:0] viol;
  logic [VCH:0] uflow;
  logic         in_range;
  logic         fwd;
  logic         unused_dbg;

  // Router/channel ids are kept only for debug visibility.
  assign unused_dbg = ^{ROUTERID, PCHID};

  // VC ids above the top VC are ignored entirely.
  assign in_range = (ivch <= CHW'(VCH));
  assign fwd      = ivalid && in_range && !(|viol);

  for (genvar v = 0; v < NVC; v++) begin : g_vc
    assign sel[v] = ivalid && in_range && (ivch == CHW'(v));

    credit_cnt #(
      .BUF_DEPTH (BUF_DEPTH)
    ) u_cnt (
      .clk   (clk),
      .rst_  (rst_),
      .sel   (sel[v]),
      .ftype (flit_type(idata)),
      .ack   (iack[v]),
      .rdy   (ordy[v]),
      .lck   (olck[v]),
      .viol  (viol[v]),
      .uflow (uflow[v])
    );
  end

  // Link output register; an idle cycle drives zero data.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      ovalid <= 1'b0;
      odata  <= {(DATAW+1){1'b0}};
      ovch   <= {CHW{1'b0}};
    end else begin
      ovalid <= fwd;
      odata  <= fwd ? idata : {(DATAW+1){1'b0}};
      ovch   <= fwd ? ivch  : {CHW{1'b0}};
    end
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      oerr <= 1'b0;
    end else begin
      oerr <= ERRCHK & (oerr | (|viol) | (|uflow));
    end
  end
endmodule

// File: tb/tb_outputc.sv
// tb_outputc: scoreboard bench for outputc (BUF_DEPTH = 4, 3 VCs).
module tb_outputc;
  import outputc_pkg::*;

  localparam int NV = VCH + 1;
  localparam int BD = 4;

  logic             clk    = 1'b0;
  logic             rst_   = 1'b1;
  logic [DATAW:0]   idata  = '0;
  logic             ivalid = 1'b0;
  logic [VCHW:0]    ivch   = '0;
  logic [VCH:0]     iack   = '0;
  logic [DATAW:0]   odata;
  logic             ovalid;
  logic [VCHW:0]    ovch;
  logic [VCH:0]     ordy;
  logic [VCH:0]     olck;
  logic             oerr;

  outputc #(.ROUTERID(0), .PCHID(0), .BUF_DEPTH(BD)) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .iack(iack), .odata(odata), .ovalid(ovalid), .ovch(ovch),
    .ordy(ordy), .olck(olck), .oerr(oerr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           valid;
    logic [DATAW:0] data;
    logic [VCHW:0]  vch;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         total = 0;
  int         bad   = 0;
  int         mcred[NV];
  logic [VCH:0] mlck;
  logic       merr;

  function automatic logic [DATAW:0] flit(input logic [1:0] ty, input int pl);
    logic [DATAW:0] d;
    d = {ty, 30'(pl)};
    return d;
  endfunction

  function automatic logic [VCH:0] exp_rdy();
    logic [VCH:0] r;
    for (int i = 0; i < NV; i++) r[i] = (mcred[i] != 0);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) mcred[i] = BD;
    mlck = '0;
    merr = 1'b0;
    sb.delete();
  endtask

  // Apply one cycle of stimulus, advance the reference model, queue the expected link word.
  task automatic drive(input logic v, input logic [DATAW:0] d, input logic [VCHW:0] ch,
                       input logic [VCH:0] ack);
    logic sel, viol, acc, dec;
    logic [1:0] ty;
    int c;
    c = int'(ch);
    ty = d[TYPE_MSB:TYPE_LSB];
    sel = v && (c <= VCH);
    viol = 1'b0;
`ifdef OUTPUTC_ERRCHK_EN
    if (sel) viol = (mcred[c] == 0) || (ty == TYPE_HEAD && mlck[c]) || (ty == TYPE_TAIL && !mlck[c]);
`endif
    acc = sel && !viol;
    if (viol) merr = 1'b1;
    for (int i = 0; i < NV; i++) begin
      dec = acc && (c == i);
      if (dec && !ack[i]) begin
        if (mcred[i] > 0) mcred[i]--;
      end else if (ack[i] && !dec) begin
        if (mcred[i] == BD) begin
`ifdef OUTPUTC_ERRCHK_EN
          merr = 1'b1;
`endif
        end else mcred[i]++;
      end
      if (dec && ty == TYPE_HEAD) mlck[i] = 1'b1;
      if (dec && ty == TYPE_TAIL) mlck[i] = 1'b0;
    end
    e.valid = acc;
    e.data  = acc ? d : '0;
    e.vch   = acc ? ch : '0;
    sb.push_back(e);
    ivalid = v; idata = d; ivch = ch; iack = ack;
    @(posedge clk);
    #1;
    ivalid = 1'b0; idata = '0; ivch = '0; iack = '0;
  endtask

  task automatic test_reset();
    rst_ = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ordy !== 3'b111) begin bad++; $display("FAIL reset_ordy: got %b need 111", ordy); end
    total++; if (olck !== 3'b000) begin bad++; $display("FAIL reset_olck: got %b need 000", olck); end
    total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL reset_ovalid: got %b need 0", ovalid); end
    total++; if (oerr !== 1'b0) begin bad++; $display("FAIL reset_oerr: got %b need 0", oerr); end
    total++; if (odata !== '0 || ovch !== '0) begin bad++; $display("FAIL reset_odata: got %h/%0d need 0/0", odata, ovch); end
    rst_ = 1'b0;
    model_reset();
  endtask

  task automatic test_exhaustion();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, flit(TYPE_HEADTAIL, 'h100 + i), 2'd1, 3'b000);
      e = sb.pop_front();
      total++; if ({ovalid, odata, ovch} !== e) begin bad++; $display("FAIL exhaust_out%0d: got %b/%h/%0d need %b/%h/%0d", i, ovalid, odata, ovch, e.valid, e.data, e.vch); end
      total++; if (olck !== 3'b000) begin bad++; $display("FAIL exhaust_olck%0d: got %b need 000", i, olck); end
    end
    total++; if (ordy !== 3'b101) begin bad++; $display("FAIL exhaust_ordy: got %b need 101", ordy); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 2'd0, 3'b010);
      e = sb.pop_front();
      total++; if ({ovalid, odata, ovch} !== e) begin bad++; $display("FAIL exhaust_ack_out%0d: got %b/%h need %b/%h", i, ovalid, odata, e.valid, e.data); end
      if (i == 0) begin
        total++; if (ordy !== 3'b111) begin bad++; $display("FAIL exhaust_ack_ordy: got %b need 111", ordy); end
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [VCH:0] acks [5] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
    logic         rdy0 [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, flit(TYPE_HEADTAIL, 'h200 + i), 2'd0, acks[i]);
      e = sb.pop_front();
      total++; if ({ovalid, odata, ovch} !== e) begin bad++; $display("FAIL simul_out%0d: got %b/%h/%0d need %b/%h/%0d", i, ovalid, odata, ovch, e.valid, e.data, e.vch); end
      total++; if (ordy[0] !== rdy0[i] || ordy !== exp_rdy()) begin bad++; $display("FAIL simul_ordy%0d: got %b need %b", i, ordy, exp_rdy()); end
    end
    repeat (4) begin
      drive(1'b0, '0, 2'd0, 3'b001);
      e = sb.pop_front();
    end
    total++; if (ordy !== 3'b111) begin bad++; $display("FAIL simul_restore: got %b need 111", ordy); end
  endtask

  task automatic test_ignored_vch();
    drive(1'b1, flit(TYPE_HEAD, 'h300), 2'd3, 3'b000);
    e = sb.pop_front();
    total++; if ({ovalid, odata, ovch} !== e) begin bad++; $display("FAIL ignore_out: got %b/%h need %b/%h", ovalid, odata, e.valid, e.data); end
    total++; if (ordy !== 3'b111 || olck !== 3'b000) begin bad++; $display("FAIL ignore_state: got rdy=%b lck=%b need 111/000", ordy, olck); end
  endtask

  task automatic test_lock();
    logic [1:0] tys [4] = '{TYPE_HEAD, TYPE_BODY, TYPE_BODY, TYPE_TAIL};
    logic       lk  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, flit(tys[i], 'h400 + i), 2'd2, 3'b000);
      e = sb.pop_front();
      total++; if ({ovalid, odata, ovch} !== e) begin bad++; $display("FAIL lock_out%0d: got %b/%h/%0d need %b/%h/%0d", i, ovalid, odata, ovch, e.valid, e.data, e.vch); end
      total++; if (olck[2] !== lk[i] || olck !== mlck) begin bad++; $display("FAIL lock_olck%0d: got %b need %b", i, olck, mlck); end
    end
    total++; if (ordy !== 3'b011) begin bad++; $display("FAIL lock_ordy: got %b need 011", ordy); end
    repeat (4) begin
      drive(1'b0, '0, 2'd0, 3'b100);
      e = sb.pop_front();
    end
  endtask

`ifdef OUTPUTC_ERRCHK_EN
  task automatic test_errchk();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, flit(TYPE_HEADTAIL, 'h500 + i), 2'd1, 3'b000);
      e = sb.pop_front();
      total++; if ({ovalid, odata, ovch} !== e) begin bad++; $display("FAIL err_ovf_out%0d: got %b/%h need %b/%h", i, ovalid, odata, e.valid, e.data); end
    end
    total++; if (oerr !== 1'b1) begin bad++; $display("FAIL err_ovf_oerr: got %b need 1", oerr); end
    drive(1'b1, flit(TYPE_TAIL, 'h510), 2'd2, 3'b000);
    e = sb.pop_front();
    total++; if ({ovalid, olck} !== {e.valid, mlck}) begin bad++; $display("FAIL err_tail_idle: got v=%b lck=%b need v=%b lck=%b", ovalid, olck, e.valid, mlck); end
    total++; if (oerr !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b need 1", oerr); end
    drive(1'b0, '0, 2'd0, 3'b001);
    e = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, flit(TYPE_HEADTAIL, 'h520 + i), 2'd0, 3'b000);
      e = sb.pop_front();
    end
    total++; if (ordy !== 3'b100) begin bad++; $display("FAIL err_uflow_sat: got %b need 100", ordy); end
    repeat (4) begin
      drive(1'b0, '0, 2'd0, 3'b011);
      e = sb.pop_front();
    end
    total++; if (ordy !== 3'b111 || oerr !== 1'b1) begin bad++; $display("FAIL err_restore: got rdy=%b err=%b need 111/1", ordy, oerr); end
  endtask
`else
  task automatic test_nochk();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, flit(TYPE_HEADTAIL, 'h500 + i), 2'd1, 3'b000);
      e = sb.pop_front();
      total++; if ({ovalid, odata, ovch} !== e) begin bad++; $display("FAIL nochk_out%0d: got %b/%h/%0d need %b/%h/%0d", i, ovalid, odata, ovch, e.valid, e.data, e.vch); end
    end
    total++; if (ordy !== 3'b101 || oerr !== 1'b0) begin bad++; $display("FAIL nochk_sat0: got rdy=%b err=%b need 101/0", ordy, oerr); end
    drive(1'b0, '0, 2'd0, 3'b010);
    e = sb.pop_front();
    total++; if (ordy !== 3'b111) begin bad++; $display("FAIL nochk_ack: got %b need 111", ordy); end
    repeat (4) begin
      drive(1'b0, '0, 2'd0, 3'b010);
      e = sb.pop_front();
    end
    total++; if (oerr !== 1'b0) begin bad++; $display("FAIL nochk_oerr: got %b need 0", oerr); end
  endtask
`endif

  task automatic test_reset_mid_packet();
    drive(1'b1, flit(TYPE_HEAD, 'h600), 2'd0, 3'b000);
    e = sb.pop_front();
    drive(1'b1, flit(TYPE_BODY, 'h601), 2'd0, 3'b000);
    e = sb.pop_front();
    total++; if (olck !== 3'b001 || ovalid !== 1'b1) begin bad++; $display("FAIL mid_pre: got lck=%b v=%b need 001/1", olck, ovalid); end
    #2 rst_ = 1'b1;
    #1;
    total++; if (olck !== 3'b000) begin bad++; $display("FAIL mid_olck: got %b need 000", olck); end
    total++; if (ovalid !== 1'b0) begin bad++; $display("FAIL mid_ovalid: got %b need 0", ovalid); end
    total++; if (ordy !== 3'b111 || oerr !== 1'b0) begin bad++; $display("FAIL mid_rdy_err: got %b/%b need 111/0", ordy, oerr); end
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b0;
    model_reset();
    drive(1'b1, flit(TYPE_HEAD, 'h610), 2'd0, 3'b000);
    e = sb.pop_front();
    total++; if ({ovalid, odata, ovch} !== e) begin bad++; $display("FAIL mid_new_out: got %b/%h need %b/%h", ovalid, odata, e.valid, e.data); end
    total++; if (olck !== 3'b001 || ordy !== exp_rdy()) begin bad++; $display("FAIL mid_new_lock: got lck=%b rdy=%b need 001/%b", olck, ordy, exp_rdy()); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_exhaustion();
    test_simultaneous();
    test_ignored_vch();
    test_lock();
`ifdef OUTPUTC_ERRCHK_EN
    test_errchk();
`else
    test_nochk();
`endif
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
